// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter fed by a small ready/valid byte FIFO; bit period N = max(io_CLK_PER_BIT, 2),
// latched per frame. The start bit begins one clock after a push into an empty idle block; io_ready_o = !full.
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 8,
  parameter int CPB_W      = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [CPB_W-1:0]              io_CLK_PER_BIT,
  input  logic [DATA_W-1:0]             io_data_i,
  input  logic                          io_valid_i,
  output logic                          io_ready_o,
  output logic                          io_tx_o,
  output logic                          io_busy_o,
  output logic                          io_done_o,
  output logic [$clog2(FIFO_DEPTH):0]   io_count_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(DATA_W);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr, count;
  logic              full, empty, push, pop;

  state_t            state, state_nxt;
  logic [CPB_W-1:0]  clk_cnt, clk_cnt_nxt, n_bit, n_bit_nxt, n_eff;
  logic [BW-1:0]     bit_idx, bit_idx_nxt;
  logic [DATA_W-1:0] shift, shift_nxt;
  logic              tx_q, tx_nxt;
  logic              bit_end, load;

  // Extra pointer MSB separates full from empty.
  assign count = wr_ptr - rd_ptr;
  assign full  = (count == (AW+1)'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign push  = io_valid_i && !full;

  assign n_eff   = (io_CLK_PER_BIT < CPB_W'(2)) ? CPB_W'(2) : io_CLK_PER_BIT;
  assign bit_end = (clk_cnt == n_bit - CPB_W'(1));

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[AW-1:0]] <= io_data_i;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      clk_cnt <= '0;
      n_bit   <= CPB_W'(2);
      bit_idx <= '0;
      shift   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state   <= state_nxt;
      clk_cnt <= clk_cnt_nxt;
      n_bit   <= n_bit_nxt;
      bit_idx <= bit_idx_nxt;
      shift   <= shift_nxt;
      tx_q    <= tx_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clk_cnt_nxt = clk_cnt + CPB_W'(1);
    n_bit_nxt   = n_bit;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    tx_nxt      = tx_q;
    load        = 1'b0;
    pop         = 1'b0;
    io_done_o   = 1'b0;
    case (state)
      S_IDLE: begin
        clk_cnt_nxt = '0;
        tx_nxt      = 1'b1;
        load        = !empty;
      end
      S_START: begin
        if (bit_end) begin
          clk_cnt_nxt = '0;
          bit_idx_nxt = '0;
          state_nxt   = S_DATA;
          tx_nxt      = shift[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          clk_cnt_nxt = '0;
          if (bit_idx == BW'(DATA_W-1)) begin
            state_nxt = S_STOP;
            tx_nxt    = 1'b1;
          end else begin
            bit_idx_nxt = bit_idx + BW'(1);
            shift_nxt   = shift >> 1;
            tx_nxt      = shift[1];
          end
        end
      end
      S_STOP: begin
        if (bit_end) begin
          io_done_o   = 1'b1;
          clk_cnt_nxt = '0;
          state_nxt   = S_IDLE;
          tx_nxt      = 1'b1;
          load        = !empty;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // Loading from STOP chains frames with no idle clock between them.
    if (load) begin
      pop         = 1'b1;
      shift_nxt   = mem[rd_ptr[AW-1:0]];
      n_bit_nxt   = n_eff;
      clk_cnt_nxt = '0;
      state_nxt   = S_START;
      tx_nxt      = 1'b0;
    end
  end

  assign io_ready_o = !full;
  assign io_tx_o    = tx_q;
  assign io_busy_o  = (state != S_IDLE) || !empty;
  assign io_count_o = count;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a frame-decoding receiver plus hand-computed timing expectations.
module tb_uart_tx_fifo;

  logic        clock, reset;
  logic [15:0] io_CLK_PER_BIT;
  logic [7:0]  io_data_i;
  logic        io_valid_i;
  logic        io_ready_o, io_tx_o, io_busy_o, io_done_o;
  logic [2:0]  io_count_o;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  int mon_n = 4;
  int rx_bad = 0;
  logic [7:0] rx_bytes[$];
  int rx_start[$];
  int done_q[$];

  uart_tx_fifo dut (
    .clock          (clock),
    .reset          (reset),
    .io_CLK_PER_BIT (io_CLK_PER_BIT),
    .io_data_i      (io_data_i),
    .io_valid_i     (io_valid_i),
    .io_ready_o     (io_ready_o),
    .io_tx_o        (io_tx_o),
    .io_busy_o      (io_busy_o),
    .io_done_o      (io_done_o),
    .io_count_o     (io_count_o)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  initial forever begin
    @(posedge clock); #1;
    if (io_done_o === 1'b1) done_q.push_back(cyc);
  end

  // Receiver: on a falling edge, take 10 bits of mon_n clocks each and require every sample of a bit to agree.
  initial begin
    int n, f, bad;
    logic ab, s0;
    logic [9:0] bits;
    logic prev;
    prev = 1'b1;
    forever begin
      @(posedge clock); #1;
      if (reset && prev && io_tx_o === 1'b0) begin
        n = mon_n; f = cyc; bad = 0; ab = 1'b0; bits = '0; s0 = 1'b0;
        for (int j = 0; j < 10; j++) begin
          for (int c = 0; c < n; c++) begin
            if (j != 0 || c != 0) begin @(posedge clock); #1; end
            if (!reset) ab = 1'b1;
            if (c == 0) begin s0 = io_tx_o; bits[j] = io_tx_o; end
            else if (io_tx_o !== s0) bad++;
          end
        end
        if (bits[0] !== 1'b0) bad++;
        if (bits[9] !== 1'b1) bad++;
        if (!ab) begin
          rx_bytes.push_back(bits[8:1]);
          rx_start.push_back(f);
          rx_bad += bad;
        end
      end
      prev = io_tx_o;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic push(input logic [7:0] b, output int acc, output int waits);
    io_data_i  = b;
    io_valid_i = 1'b1;
    waits = 0;
    while (io_ready_o !== 1'b1 && waits < 2000) begin
      @(posedge clock); #1;
      waits++;
    end
    @(posedge clock); #1;
    acc = cyc;
  endtask

  task automatic wait_idle(input string tag, input int budget, output int t);
    int i;
    i = 0;
    while (io_busy_o !== 1'b0 && i < budget) begin
      @(posedge clock); #1;
      i++;
    end
    t = cyc;
    check(tag, i < budget, 1);
  endtask

  task automatic clear_rx();
    rx_bytes.delete();
    rx_start.delete();
    done_q.delete();
    rx_bad = 0;
  endtask

  task automatic idle_clocks(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  initial begin
    int a, w, t, errs, wsum;
    int acc[6];
    logic [7:0] exp3[4];
    exp3[0] = 8'hA5; exp3[1] = 8'hFF; exp3[2] = 8'h00; exp3[3] = 8'h0F;

    reset = 1'b1; io_valid_i = 1'b0; io_data_i = '0; io_CLK_PER_BIT = 16'd217;
    #2 reset = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    check("rst_tx", io_tx_o, 1);
    check("rst_ready", io_ready_o, 1);
    check("rst_busy", io_busy_o, 0);
    check("rst_count", io_count_o, 0);
    check("rst_done", io_done_o, 0);
    reset = 1'b1;
    errs = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clock); #1;
      if (io_tx_o !== 1'b1 || io_ready_o !== 1'b1 || io_busy_o !== 1'b0 ||
          io_count_o !== 3'd0 || io_done_o !== 1'b0) errs++;
    end
    check("idle_1000", errs, 0);

    // N=217, single byte 0x13
    clear_rx(); mon_n = 217;
    push(8'h13, a, w); io_valid_i = 1'b0;
    wait_idle("t2_idle", 5000, t); idle_clocks(5);
    check("t2_frames", rx_bytes.size(), 1);
    check("t2_byte", rx_bytes[0], 8'h13);
    check("t2_fall", rx_start[0], a + 1);
    check("t2_bits", rx_bad, 0);
    check("t2_ndone", done_q.size(), 1);
    check("t2_done_at", done_q[0], a + 1 + 2169);

    // N=4, four back-to-back bytes
    clear_rx(); io_CLK_PER_BIT = 16'd4; mon_n = 4; wsum = 0;
    for (int i = 0; i < 4; i++) begin push(exp3[i], acc[i], w); wsum += w; end
    io_valid_i = 1'b0;
    check("t3_ready_held", wsum, 0);
    wait_idle("t3_idle", 1000, t);
    check("t3_busy_drop", t, done_q[3] + 1);
    idle_clocks(5);
    check("t3_frames", rx_bytes.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("t3_byte%0d", i), rx_bytes[i], exp3[i]);
    for (int i = 1; i < 4; i++) check($sformatf("t3_gap%0d", i), rx_start[i] - rx_start[i-1], 40);
    check("t3_bits", rx_bad, 0);
    check("t3_ndone", done_q.size(), 4);

    // N=4, six bytes under continuous valid
    clear_rx();
    for (int i = 0; i < 6; i++) begin
      push(8'(i + 1), acc[i], w);
      if (i == 4) begin
        check("t4_count_full", io_count_o, 4);
        check("t4_ready_full", io_ready_o, 0);
      end
    end
    io_valid_i = 1'b0;
    check("t4_acc5", acc[4] - acc[0], 4);
    check("t4_acc6", acc[5] - acc[0], 42);
    wait_idle("t4_idle", 1000, t); idle_clocks(5);
    check("t4_frames", rx_bytes.size(), 6);
    for (int i = 0; i < 6; i++) check($sformatf("t4_byte%0d", i), rx_bytes[i], i + 1);
    check("t4_bits", rx_bad, 0);

    // N changes 8 -> 3 during the first frame
    clear_rx(); io_CLK_PER_BIT = 16'd8; mon_n = 8;
    push(8'h55, a, w); push(8'hA3, acc[0], w); io_valid_i = 1'b0;
    idle_clocks(20);
    io_CLK_PER_BIT = 16'd3; mon_n = 3;
    wait_idle("t5_idle", 1000, t); idle_clocks(5);
    check("t5_frames", rx_bytes.size(), 2);
    check("t5_byte0", rx_bytes[0], 8'h55);
    check("t5_byte1", rx_bytes[1], 8'hA3);
    check("t5_len0", rx_start[1] - rx_start[0], 80);
    check("t5_len1", done_q[1] - rx_start[1], 29);
    check("t5_bits", rx_bad, 0);

    // N below 2 is clamped to 2
    clear_rx(); mon_n = 2;
    io_CLK_PER_BIT = 16'd0; push(8'h3C, a, w); io_valid_i = 1'b0;
    wait_idle("t6_idle0", 500, t); idle_clocks(3);
    io_CLK_PER_BIT = 16'd1; push(8'hC3, a, w); io_valid_i = 1'b0;
    wait_idle("t6_idle1", 500, t); idle_clocks(3);
    check("t6_frames", rx_bytes.size(), 2);
    check("t6_byte0", rx_bytes[0], 8'h3C);
    check("t6_byte1", rx_bytes[1], 8'hC3);
    check("t6_len0", done_q[0] - rx_start[0], 19);
    check("t6_len1", done_q[1] - rx_start[1], 19);
    check("t6_bits", rx_bad, 0);

    // Reset during data bit 3 of 0x55 with two bytes queued
    clear_rx(); io_CLK_PER_BIT = 16'd4; mon_n = 4;
    push(8'h55, a, w); push(8'h11, w, t); push(8'h22, w, t); io_valid_i = 1'b0;
    check("t7_queued", io_count_o, 2);
    t = 0;
    while (cyc < a + 1 + 17 && t < 100) begin @(posedge clock); #1; t++; end
    check("t7_pre_tx", io_tx_o, 0);
    #2 reset = 1'b0;
    #1;
    check("t7_async_tx", io_tx_o, 1);
    check("t7_count", io_count_o, 0);
    check("t7_ready", io_ready_o, 1);
    check("t7_busy", io_busy_o, 0);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    errs = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clock); #1;
      if (io_tx_o !== 1'b1 || io_busy_o !== 1'b0 || io_count_o !== 3'd0) errs++;
    end
    check("t7_quiet", errs, 0);
    check("t7_frames", rx_bytes.size(), 0);
    check("t7_ndone", done_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
